// File: rtl/clock_ctrl_pkg.sv
// Shared constants for the clock time-set controller.
// Mode encodings and BCD field limits.
package clock_ctrl_pkg;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam logic [7:0] BCD_MAX_HOUR   = 8'h23;
  localparam logic [7:0] BCD_MAX_MINSEC = 8'h59;

  function automatic logic [1:0] next_mode(
    input logic [1:0] m
  );
    return m + 2'd1;
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button and display bundle of the clock controller.
// master drives buttons, slave drives the display.
interface clock_set_ctrl_if;

  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] cnt_sec1;
  logic [3:0] cnt_sec10;
  logic [3:0] cnt_min1;
  logic [3:0] cnt_min10;
  logic [3:0] cnt_hour1;
  logic [3:0] cnt_hour10;
  logic [1:0] set_mode;
  logic       blink;
  logic       tick_1s;

  modport master (
    output btn_mode, btn_up, btn_down,
    input  cnt_sec1, cnt_sec10,
    input  cnt_min1, cnt_min10,
    input  cnt_hour1, cnt_hour10,
    input  set_mode, blink, tick_1s
  );

  modport slave (
    input  btn_mode, btn_up, btn_down,
    output cnt_sec1, cnt_sec10,
    output cnt_min1, cnt_min10,
    output cnt_hour1, cnt_hour10,
    output set_mode, blink, tick_1s
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter, modulo MAX+1.
// carry flags the inc that wraps MAX to 00.
module bcd_mod_counter
  import clock_ctrl_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MAX_MINSEC
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry
);

  logic [7:0] q_inc;
  logic [7:0] q_dec;

  always_comb begin
    q_inc = {q[7:4], q[3:0] + 4'd1};
    if (q == MAX)
      q_inc = 8'h00;
    else if (q[3:0] == 4'd9)
      q_inc = {q[7:4] + 4'd1, 4'd0};

    q_dec = {q[7:4], q[3:0] - 4'd1};
    if (q == 8'h00)
      q_dec = MAX;
    else if (q[3:0] == 4'd0)
      q_dec = {q[7:4] - 4'd1, 4'd9};
  end

  assign carry = inc && (q == MAX);

  always_ff @(posedge clk) begin
    if (resetn) begin
      q <= 8'h00;
    end else begin
      unique case (1'b1)
        clr:     q <= 8'h00;
        inc:     q <= q_inc;
        dec:     q <= q_dec;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-keeping and time-setting controller.
// 1 s tick, BCD hh:mm:ss, set FSM, repeat, blink.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 25000000,
  parameter int REPEAT_CYC = 12500000,
  parameter int BLINK_DIV  = 6250000
) (
  input  logic       clk,
  input  logic       resetn,
  clock_set_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(BLINK_DIV - 1);

  logic [1:0]    mode;
  logic          prev_mode;
  logic          prev_up;
  logic          prev_down;
  logic [TW-1:0] tick_cnt;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blk_cnt;
  logic          tick_q;
  logic          blink_q;

  logic rise_mode, rise_up, rise_down;
  logic run, tick_hit;
  logic up_alone, dn_alone, rep_hit;
  logic step_up, step_dn, rep_clr;

  logic [7:0] sec_q, min_q, hour_q;
  logic       sec_carry, min_carry, hour_carry;
  logic       sec_clr, min_inc, min_dec;
  logic       hour_inc, hour_dec;

  assign rise_mode = bus.btn_mode & ~prev_mode;
  assign rise_up   = bus.btn_up   & ~prev_up;
  assign rise_down = bus.btn_down & ~prev_down;

  assign run      = (mode == MODE_RUN);
  assign tick_hit = run && (tick_cnt == TICK_LAST);

  assign up_alone = bus.btn_up & ~bus.btn_down;
  assign dn_alone = bus.btn_down & ~bus.btn_up;
  assign rep_hit  = (rep_cnt == REP_LAST);

  // A mode change always swallows the step.
  assign step_up = ~run & ~rise_mode & up_alone
                 & (rise_up | rep_hit);
  assign step_dn = ~run & ~rise_mode & dn_alone
                 & (rise_down | rep_hit);

  assign rep_clr = run | rise_mode
                 | ~(up_alone | dn_alone)
                 | rise_up | rise_down | rep_hit;

  assign sec_clr  = (mode == MODE_SET_SEC)
                  & (step_up | step_dn);
  assign min_inc  = run ? sec_carry
                  : ((mode == MODE_SET_MIN) & step_up);
  assign min_dec  = (mode == MODE_SET_MIN) & step_dn;
  assign hour_inc = run ? min_carry
                  : ((mode == MODE_SET_HOUR) & step_up);
  assign hour_dec = (mode == MODE_SET_HOUR) & step_dn;

  bcd_mod_counter #(.MAX(BCD_MAX_MINSEC)) u_sec (
    .clk    (clk),
    .resetn (resetn),
    .inc    (tick_hit),
    .dec    (1'b0),
    .clr    (sec_clr),
    .q      (sec_q),
    .carry  (sec_carry)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_MINSEC)) u_min (
    .clk    (clk),
    .resetn (resetn),
    .inc    (min_inc),
    .dec    (min_dec),
    .clr    (1'b0),
    .q      (min_q),
    .carry  (min_carry)
  );

  bcd_mod_counter #(.MAX(BCD_MAX_HOUR)) u_hour (
    .clk    (clk),
    .resetn (resetn),
    .inc    (hour_inc),
    .dec    (hour_dec),
    .clr    (1'b0),
    .q      (hour_q),
    .carry  (hour_carry)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      prev_mode <= 1'b0;
      prev_up   <= 1'b0;
      prev_down <= 1'b0;
      mode      <= MODE_RUN;
      tick_cnt  <= '0;
      tick_q    <= 1'b0;
      rep_cnt   <= '0;
    end else begin
      prev_mode <= bus.btn_mode;
      prev_up   <= bus.btn_up;
      prev_down <= bus.btn_down;
      if (rise_mode)
        mode <= next_mode(mode);
      tick_q <= tick_hit;
      if (!run || tick_hit)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
      if (rep_clr)
        rep_cnt <= '0;
      else
        rep_cnt <= rep_cnt + 1'b1;
    end
  end

  // Each SET entry restarts the blink phase lit.
  always_ff @(posedge clk) begin
    if (resetn) begin
      blink_q <= 1'b0;
      blk_cnt <= '0;
    end else if (rise_mode) begin
      blink_q <= (mode != MODE_SET_SEC);
      blk_cnt <= '0;
    end else if (run) begin
      blink_q <= 1'b0;
      blk_cnt <= '0;
    end else if (blk_cnt == BLK_LAST) begin
      blink_q <= ~blink_q;
      blk_cnt <= '0;
    end else begin
      blk_cnt <= blk_cnt + 1'b1;
    end
  end

  assign bus.cnt_sec1   = sec_q[3:0];
  assign bus.cnt_sec10  = sec_q[7:4];
  assign bus.cnt_min1   = min_q[3:0];
  assign bus.cnt_min10  = min_q[7:4];
  assign bus.cnt_hour1  = hour_q[3:0];
  assign bus.cnt_hour10 = hour_q[7:4];
  assign bus.set_mode   = mode;
  assign bus.blink      = blink_q;
  assign bus.tick_1s    = tick_q;

  logic unused_ok;
  assign unused_ok = hour_carry;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl.
// Small dividers: TICK 10, REPEAT 8, BLINK 4.
module tb_clock_set_ctrl;
  import clock_ctrl_pkg::*;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(
    .TICK_DIV   (10),
    .REPEAT_CYC (8),
    .BLINK_DIV  (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(
    input string tag,
    input int    obs,
    input int    exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic int hms();
    return {8'h00,
            bus.cnt_hour10, bus.cnt_hour1,
            bus.cnt_min10,  bus.cnt_min1,
            bus.cnt_sec10,  bus.cnt_sec1};
  endfunction

  task automatic press(input int which);
    case (which)
      0:       bus.btn_mode = 1'b1;
      1:       bus.btn_up   = 1'b1;
      default: bus.btn_down = 1'b1;
    endcase
    cycles(1);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    cycles(1);
  endtask

  initial begin
    int ticks;
    n_checks = 0;
    n_fail   = 0;
    resetn       = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    cycles(3);
    check("rst_time",  hms(), 'h000000);
    check("rst_mode",  bus.set_mode, 0);
    check("rst_blink", bus.blink, 0);
    check("rst_tick",  bus.tick_1s, 0);
    resetn = 1'b0;

    cycles(9);
    check("pre_tick", bus.tick_1s, 0);
    check("pre_time", hms(), 'h000000);
    cycles(1);
    check("tick1",    bus.tick_1s, 1);
    check("time1",    hms(), 'h000001);
    cycles(1);
    check("tick1_off", bus.tick_1s, 0);
    cycles(599);
    check("time_61s", hms(), 'h000101);

    press(0);
    check("mode_hour", bus.set_mode, 1);
    check("blink_on",  bus.blink, 1);
    cycles(2);
    check("blink_hold", bus.blink, 1);
    cycles(1);
    check("blink_tog0", bus.blink, 0);
    cycles(4);
    check("blink_tog1", bus.blink, 1);
    press(2);
    check("hour_dn_wrap", hms(), 'h230101);
    press(1);
    check("hour_up_wrap", hms(), 'h000101);
    press(2);
    check("hour_dn_again", hms(), 'h230101);
    ticks = 0;
    for (int i = 0; i < 25; i++) begin
      cycles(1);
      ticks += int'(bus.tick_1s);
    end
    check("no_tick_set", ticks, 0);
    check("hold_set", hms(), 'h230101);

    press(0);
    check("mode_min", bus.set_mode, 2);
    press(2);
    press(2);
    press(2);
    check("min_58", hms(), 'h235801);
    bus.btn_up = 1'b1;
    cycles(1);
    check("rep_rise", hms(), 'h235901);
    cycles(7);
    check("rep_wait", hms(), 'h235901);
    cycles(1);
    check("rep_8", hms(), 'h230001);
    cycles(7);
    check("rep_wait2", hms(), 'h230001);
    cycles(1);
    check("rep_16", hms(), 'h230101);
    cycles(3);
    bus.btn_up = 1'b0;
    cycles(1);
    check("rep_end", hms(), 'h230101);

    press(2);
    press(2);
    press(0);
    check("mode_sec", bus.set_mode, 3);
    press(1);
    check("sec_clr", hms(), 'h235900);
    press(0);
    check("mode_run", bus.set_mode, 0);
    check("blink_run", bus.blink, 0);
    cycles(8);
    check("run_pre_tick", bus.tick_1s, 0);
    cycles(1);
    check("run_tick", bus.tick_1s, 1);
    check("run_time", hms(), 'h235901);
    cycles(570);
    check("t_58", hms(), 'h235958);
    cycles(10);
    check("t_59", hms(), 'h235959);
    cycles(9);
    check("t_59_hold", hms(), 'h235959);
    cycles(1);
    check("t_wrap", hms(), 'h000000);
    check("t_wrap_tick", bus.tick_1s, 1);

    press(0);
    check("mode_hour2", bus.set_mode, 1);
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    cycles(12);
    check("both_held", hms(), 'h000000);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    cycles(1);
    bus.btn_mode = 1'b1;
    bus.btn_up   = 1'b1;
    cycles(1);
    check("mode_vs_up", bus.set_mode, 2);
    check("mode_vs_up_t", hms(), 'h000000);
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    cycles(1);

    press(0);
    press(0);
    check("mode_run2", bus.set_mode, 0);
    cycles(369);
    check("t_37", hms(), 'h000037);
    press(0);
    press(0);
    press(0);
    check("mode_sec2", bus.set_mode, 3);
    check("sec37_held", hms(), 'h000037);
    press(1);
    check("sec37_clr", hms(), 'h000000);
    press(0);
    cycles(8);
    check("lat_pre", bus.tick_1s, 0);
    cycles(1);
    check("lat_tick", bus.tick_1s, 1);
    check("lat_time", hms(), 'h000001);

    press(0);
    bus.btn_up = 1'b1;
    cycles(1);
    check("mid_rep_step", hms(), 'h010001);
    cycles(5);
    resetn = 1'b1;
    cycles(1);
    bus.btn_up = 1'b0;
    check("mid_rst_time",  hms(), 'h000000);
    check("mid_rst_mode",  bus.set_mode, 0);
    check("mid_rst_blink", bus.blink, 0);
    resetn = 1'b0;
    cycles(9);
    check("post_rst_pre", bus.tick_1s, 0);
    cycles(1);
    check("post_rst_tick", bus.tick_1s, 1);
    check("post_rst_time", hms(), 'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
